instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Parametrised successor to the 8-bit instruction memory. Combines a programmable instruction store, a program counter, and a registered valid/ready output stage that feeds the decode stage. It supports:
- loading a program through a write port while halted;
- sequential fetch at one instruction per cycle;
- branch/jump redirect with flush of the in-flight instruction.

Parameters:
DATA_WIDTH, 8, instruction width in bits
ADDR_WIDTH, 8, PC and program-port address width
DEPTH, 256, number of instruction words implemented; must satisfy 1 <= DEPTH <= 2^ADDR_WIDTH
RESET_PC, 0, PC value after reset
PC_STEP, 1, PC increment per fetched instruction

Ports:
clock  input  1  system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
run  input  1  1 = fetch mode, 0 = load/halt mode
prog_we  input  1  program write enable; honoured only in LOAD state
prog_addr  input  ADDR_WIDTH  program write address
prog_data  input  DATA_WIDTH  program write data
redirect_valid  input  1  load PC with redirect_pc (branch/jump)
redirect_pc  input  ADDR_WIDTH  redirect target
instr_ready  input  1  decode accepts instruction this cycle
instr_valid  output  1  instruction/instr_pc hold a valid fetch
instruction  output  DATA_WIDTH  fetched instruction word
instr_pc  output  ADDR_WIDTH  address the instruction was fetched from
pc  output  ADDR_WIDTH  next fetch address
running  output  1  1 when the state is RUN

Behaviour:
- Reset (async, reset_n=0): state=LOAD, pc=RESET_PC, instr_valid=0, instruction=0, instr_pc=0, running=0. Memory contents are not reset.
- States: LOAD, RUN. All transitions happen on the rising edge of clock.
- LOAD:
  - prog_we=1 and prog_addr<DEPTH writes prog_data to mem[prog_addr]. prog_we with prog_addr>=DEPTH is ignored.
  - redirect_valid=1 sets pc<=redirect_pc (selects the start address).
  - run=1 moves to RUN; pc is unchanged and no fetch occurs on that edge.
  - instr_valid stays 0.
- RUN:
  - prog_we is ignored.
  - advance = !instr_valid || instr_ready.
  - Priority 1, run=0: go to LOAD, instr_valid<=0, pc is retained so fetch resumes from it.
  - Priority 2, redirect_valid=1: instr_valid<=0 (flush), pc<=redirect_pc, no fetch on this edge.
  - Priority 3, advance=1: instruction<=mem[pc] (0 if pc>=DEPTH), instr_pc<=pc, instr_valid<=1, pc<=(pc+PC_STEP) mod 2^ADDR_WIDTH.
  - Otherwise (stall, instr_valid=1 and instr_ready=0): all outputs and pc hold.
- Latency and throughput:
  - The first instruction is valid 2 edges after run is sampled high: one edge for the transition, one for the fetch.
  - With instr_ready held at 1, one instruction is delivered per cycle with no bubbles.
  - After a redirect, the target instruction is valid on the edge following the redirect edge (1 bubble).
- Handshake: a transfer occurs on an edge where instr_valid=1 and instr_ready=1. While stalled, instruction and instr_pc are stable.
- Wrap-around: pc wraps modulo 2^ADDR_WIDTH, not modulo DEPTH. Addresses >= DEPTH read as 0 (NOP).
- Simultaneous events:
  - run=0 together with redirect_valid in RUN: the state goes to LOAD and the redirect is discarded.
  - A redirect during a stall drops the unaccepted instruction.
- Memory read is synchronous, with a registered output. Write and fetch never coincide because of the state gating.
- Reset mid-operation forces the reset values immediately and asynchronously. Previously loaded memory contents remain valid after reset is released.

Test Plan:
- Load then fetch: with run=0, write mem[0..5]=08,28,40,60,88,B0, then set run=1 with instr_ready=1. Required: instr_valid rises 2 edges after run is sampled; instruction sequence 08,28,40,60,88,B0 on consecutive cycles; instr_pc 0..5; pc=6 after the sixth fetch.
- Stall: deassert instr_ready while instruction=40 (instr_pc=2) for 3 cycles. Required: instruction=40, instr_pc=2 and pc=3 all hold; the next accepted instruction is 60.
- Redirect: assert redirect_valid with redirect_pc=1 while instr_pc=4. Required: instr_valid=0 for one cycle, then instruction=28 with instr_pc=1, then 40.
- Halt/resume: drop run after instr_pc=2 is accepted (pc=3). Required: running=0 and instr_valid=0. A prog_we write to address 7 lands; on re-run, fetch resumes at pc=3 with instruction 60.
- Boundary: DEPTH=6, redirect_pc=FE. Required: fetched PCs FE, FF, 00, 01 with instructions 0, 0, 08, 28. prog_we to address 6 in LOAD is ignored.
- Async reset mid-fetch: pulse reset_n low between clock edges. Required: instr_valid=0, pc=RESET_PC and running=0 immediately. After run=1, instruction 08 is fetched again because memory is retained.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: programmable instruction store, program counter and
// a registered valid/ready output stage feeding decode. LOAD state programs, RUN state fetches.
`timescale 1ns/1ps
module instruction_fetch_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int RESET_PC   = 0,
  parameter int PC_STEP    = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  instr_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  running
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  mem_we;
  logic                  advance;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Addresses at or beyond DEPTH are unimplemented: writes are dropped, reads return NOP.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  assign rd_word = in_range(pc_q) ? mem[pc_q[MEM_AW-1:0]] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (run)  state_d = S_RUN;
      S_RUN:   if (!run) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Output stage: flush and halt take priority over fetching; a stall holds everything.
  always_comb begin
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    mem_we     = 1'b0;
    advance    = !valid_q || instr_ready;
    running    = (state_q == S_RUN);
    case (state_q)
      S_LOAD: begin
        valid_d = 1'b0;
        mem_we  = prog_we && in_range(prog_addr);
        if (redirect_valid) pc_d = redirect_pc;
      end
      S_RUN: begin
        if (!run) begin
          valid_d = 1'b0;
        end else if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
        end else if (advance) begin
          instr_d    = rd_word;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + ADDR_WIDTH'(PC_STEP);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= ADDR_WIDTH'(RESET_PC);
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Program store survives reset so a loaded program can be rerun.
  always_ff @(posedge clock) begin
    if (mem_we) mem[prog_addr[MEM_AW-1:0]] <= prog_data;
  end

  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: vector tables on a full-depth and a DEPTH=6 instance,
// an asynchronous reset sequence, and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       run, prog_we, redirect_valid, instr_ready;
  logic [7:0] prog_addr, prog_data, redirect_pc;
  logic       a_valid, a_running;
  logic [7:0] a_instr, a_ipc, a_pc;

  logic       b_run, b_prog_we, b_redirect_valid, b_instr_ready;
  logic [7:0] b_prog_addr, b_prog_data, b_redirect_pc;
  logic       b_valid, b_running;
  logic [7:0] b_instr, b_ipc, b_pc;

  instruction_fetch_unit dut (
    .clock(clock), .reset_n(reset_n), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_ready(instr_ready), .instr_valid(a_valid), .instruction(a_instr),
    .instr_pc(a_ipc), .pc(a_pc), .running(a_running)
  );

  instruction_fetch_unit #(.DEPTH(6)) dut6 (
    .clock(clock), .reset_n(reset_n), .run(b_run), .prog_we(b_prog_we),
    .prog_addr(b_prog_addr), .prog_data(b_prog_data),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .instr_ready(b_instr_ready), .instr_valid(b_valid), .instruction(b_instr),
    .instr_pc(b_ipc), .pc(b_pc), .running(b_running)
  );

  typedef struct {
    logic       run, we;
    logic [7:0] addr, data;
    logic       rv;
    logic [7:0] rpc;
    logic       rdy;
    logic       ev;
    logic [7:0] ei, eipc, epc;
    logic       er;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t tab_a[$];
  vec_t tab_b[$];

  logic [7:0] m_mem [256];
  bit         m_running, m_valid;
  int         m_pc, m_instr, m_ipc;

  function automatic logic [7:0] fill(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  function automatic vec_t mk(input bit r, input bit we, input int a, input int d,
                              input bit rv, input int rpc, input bit rdy,
                              input bit ev, input int ei, input int eipc, input int epc,
                              input bit er);
    vec_t v;
    v.run = r; v.we = we; v.addr = 8'(a); v.data = 8'(d);
    v.rv = rv; v.rpc = 8'(rpc); v.rdy = rdy;
    v.ev = ev; v.ei = 8'(ei); v.eipc = 8'(eipc); v.epc = 8'(epc); v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit sel, input string tag);
    logic       o_v, o_r;
    logic [7:0] o_i, o_ipc, o_pc;
    if (!sel) begin
      run = v.run; prog_we = v.we; prog_addr = v.addr; prog_data = v.data;
      redirect_valid = v.rv; redirect_pc = v.rpc; instr_ready = v.rdy;
    end else begin
      b_run = v.run; b_prog_we = v.we; b_prog_addr = v.addr; b_prog_data = v.data;
      b_redirect_valid = v.rv; b_redirect_pc = v.rpc; b_instr_ready = v.rdy;
    end
    @(posedge clock);
    @(negedge clock);
    if (!sel) begin
      o_v = a_valid; o_r = a_running; o_i = a_instr; o_ipc = a_ipc; o_pc = a_pc;
    end else begin
      o_v = b_valid; o_r = b_running; o_i = b_instr; o_ipc = b_ipc; o_pc = b_pc;
    end
    check({tag, ".valid"},   32'(o_v),  32'(v.ev));
    check({tag, ".pc"},      32'(o_pc), 32'(v.epc));
    check({tag, ".running"}, 32'(o_r),  32'(v.er));
    if (v.ev) begin
      check({tag, ".instruction"}, 32'(o_i),   32'(v.ei));
      check({tag, ".instr_pc"},    32'(o_ipc), 32'(v.eipc));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    run = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
    redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
    b_run = 0; b_prog_we = 0; b_prog_addr = 0; b_prog_data = 0;
    b_redirect_valid = 0; b_redirect_pc = 0; b_instr_ready = 0;
    repeat (2) @(negedge clock);

    check("reset.valid",       32'(a_valid),   32'd0);
    check("reset.instruction", 32'(a_instr),   32'd0);
    check("reset.instr_pc",    32'(a_ipc),     32'd0);
    check("reset.pc",          32'(a_pc),      32'd0);
    check("reset.running",     32'(a_running), 32'd0);
    check("reset6.pc",         32'(b_pc),      32'd0);
    reset_n = 1'b1;

    // Give every location of the full-depth store a known value.
    for (int i = 0; i < 256; i++) begin
      prog_we = 1'b1; prog_addr = 8'(i); prog_data = fill(i);
      @(negedge clock);
    end
    prog_we = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = fill(i);
    m_mem[0] = 8'h08; m_mem[1] = 8'h28; m_mem[2] = 8'h40;
    m_mem[3] = 8'h60; m_mem[4] = 8'h88; m_mem[5] = 8'hB0; m_mem[7] = 8'h77;

    // Load, fetch, stall, redirect, halt/resume, wrap, halt-with-redirect.
    tab_a.push_back(mk(0,1,0,'h08,0,0,1, 0,0,0,0,0));
    tab_a.push_back(mk(0,1,1,'h28,0,0,1, 0,0,0,0,0));
    tab_a.push_back(mk(0,1,2,'h40,0,0,1, 0,0,0,0,0));
    tab_a.push_back(mk(0,1,3,'h60,0,0,1, 0,0,0,0,0));
    tab_a.push_back(mk(0,1,4,'h88,0,0,1, 0,0,0,0,0));
    tab_a.push_back(mk(0,1,5,'hB0,0,0,1, 0,0,0,0,0));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    0,0,0,0,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,'h08,0,1,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,'h28,1,2,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,'h40,2,3,1));
    tab_a.push_back(mk(1,0,0,0,0,0,0,    1,'h40,2,3,1));
    tab_a.push_back(mk(1,0,0,0,0,0,0,    1,'h40,2,3,1));
    tab_a.push_back(mk(1,0,0,0,0,0,0,    1,'h40,2,3,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,'h60,3,4,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,'h88,4,5,1));
    tab_a.push_back(mk(1,0,0,0,1,1,1,    0,0,0,1,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,'h28,1,2,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,'h40,2,3,1));
    tab_a.push_back(mk(0,0,0,0,0,0,1,    0,0,0,3,0));
    tab_a.push_back(mk(0,1,7,'h77,0,0,1, 0,0,0,3,0));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    0,0,0,3,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,'h60,3,4,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,'h88,4,5,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,'hB0,5,6,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,fill(6),6,7,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,'h77,7,8,1));
    tab_a.push_back(mk(1,0,0,0,0,0,0,    1,'h77,7,8,1));
    tab_a.push_back(mk(1,0,0,0,1,'hFE,0, 0,0,0,'hFE,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,fill(254),'hFE,'hFF,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,fill(255),'hFF,0,1));
    tab_a.push_back(mk(1,0,0,0,0,0,1,    1,'h08,0,1,1));
    tab_a.push_back(mk(0,0,0,0,1,'h50,1, 0,0,0,1,0));
    foreach (tab_a[i]) apply(tab_a[i], 1'b0, $sformatf("A[%0d]", i));

    // DEPTH=6: out-of-range writes dropped (0x80 would alias onto 0 if unchecked),
    // out-of-range reads return 0, PC wraps modulo 256.
    tab_b.push_back(mk(0,1,0,'h08,0,0,1, 0,0,0,0,0));
    tab_b.push_back(mk(0,1,1,'h28,0,0,1, 0,0,0,0,0));
    tab_b.push_back(mk(0,1,2,'h40,0,0,1, 0,0,0,0,0));
    tab_b.push_back(mk(0,1,3,'h60,0,0,1, 0,0,0,0,0));
    tab_b.push_back(mk(0,1,4,'h88,0,0,1, 0,0,0,0,0));
    tab_b.push_back(mk(0,1,5,'hB0,0,0,1, 0,0,0,0,0));
    tab_b.push_back(mk(0,1,6,'h99,0,0,1, 0,0,0,0,0));
    tab_b.push_back(mk(0,1,'h80,'h99,0,0,1, 0,0,0,0,0));
    tab_b.push_back(mk(0,0,0,0,1,'hFE,1, 0,0,0,'hFE,0));
    tab_b.push_back(mk(1,0,0,0,0,0,1,    0,0,0,'hFE,1));
    tab_b.push_back(mk(1,0,0,0,0,0,1,    1,0,'hFE,'hFF,1));
    tab_b.push_back(mk(1,0,0,0,0,0,1,    1,0,'hFF,0,1));
    tab_b.push_back(mk(1,0,0,0,0,0,1,    1,'h08,0,1,1));
    tab_b.push_back(mk(1,0,0,0,0,0,1,    1,'h28,1,2,1));
    tab_b.push_back(mk(1,0,0,0,1,5,1,    0,0,0,5,1));
    tab_b.push_back(mk(1,0,0,0,0,0,1,    1,'hB0,5,6,1));
    tab_b.push_back(mk(1,0,0,0,0,0,1,    1,0,6,7,1));
    foreach (tab_b[i]) apply(tab_b[i], 1'b1, $sformatf("B[%0d]", i));

    // Asynchronous reset between clock edges while fetching.
    run = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    reset_n = 1'b0;
    run = 1'b0;
    #1;
    check("areset.valid",       32'(a_valid),   32'd0);
    check("areset.pc",          32'(a_pc),      32'd0);
    check("areset.running",     32'(a_running), 32'd0);
    check("areset.instruction", 32'(a_instr),   32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    apply(mk(1,0,0,0,0,0,1, 0,0,0,0,1),       1'b0, "rerun0");
    apply(mk(1,0,0,0,0,0,1, 1,'h08,0,1,1),    1'b0, "rerun1");
    apply(mk(1,0,0,0,0,0,1, 1,'h28,1,2,1),    1'b0, "rerun2");

    // Randomized traffic against the behavioural model.
    m_running = 1'b1; m_valid = 1'b1; m_pc = 2; m_instr = 'h28; m_ipc = 1;
    for (int c = 0; c < 500; c++) begin
      bit         r_run, r_we, r_rv, r_rdy;
      logic [7:0] r_addr, r_data, r_rpc;
      r_run  = ($urandom % 10) != 0;
      r_we   = ($urandom % 2) != 0;
      r_rv   = ($urandom % 10) == 0;
      r_rdy  = ($urandom % 4) != 0;
      r_addr = 8'($urandom);
      r_data = 8'($urandom);
      r_rpc  = 8'($urandom);
      run = r_run; prog_we = r_we; prog_addr = r_addr; prog_data = r_data;
      redirect_valid = r_rv; redirect_pc = r_rpc; instr_ready = r_rdy;

      if (!m_running) begin
        if (r_we) m_mem[r_addr] = r_data;
        if (r_rv) m_pc = int'(r_rpc);
        if (r_run) m_running = 1'b1;
        m_valid = 1'b0;
      end else if (!r_run) begin
        m_running = 1'b0;
        m_valid   = 1'b0;
      end else if (r_rv) begin
        m_valid = 1'b0;
        m_pc    = int'(r_rpc);
      end else if (!m_valid || r_rdy) begin
        m_instr = int'(m_mem[m_pc]);
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_pc    = (m_pc + 1) % 256;
      end

      @(posedge clock);
      @(negedge clock);
      check($sformatf("rnd[%0d].valid", c),   32'(a_valid),   32'(m_valid));
      check($sformatf("rnd[%0d].pc", c),      32'(a_pc),      32'(m_pc));
      check($sformatf("rnd[%0d].running", c), 32'(a_running), 32'(m_running));
      if (m_valid) begin
        check($sformatf("rnd[%0d].instruction", c), 32'(a_instr), 32'(m_instr));
        check($sformatf("rnd[%0d].instr_pc", c),    32'(a_ipc),   32'(m_ipc));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
